// File: rtl/serial_word_comparator.sv
// Multi-cycle unsigned magnitude comparator: one bit_comparator slice is reused
// MSB-first, with its E/L/G outputs fed back as the next cycle's cascade inputs.

module bit_comparator (
   input  logic a,
   input  logic b,
   input  logic e,
   input  logic l,
   input  logic g,
   output logic e_nxt,
   output logic l_nxt,
   output logic g_nxt
);
   assign e_nxt = e & (a ~^ b);
   assign l_nxt = l | (e & ~a & b);
   assign g_nxt = g | (e & a & ~b);
endmodule

module serial_word_comparator #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst,
   input  logic                       start,
   input  logic [WIDTH-1:0]           a_in,
   input  logic [WIDTH-1:0]           b_in,
   output logic                       busy,
   output logic                       done,
   output logic                       eq,
   output logic                       lt,
   output logic                       gt,
   output logic [$clog2(WIDTH+1)-1:0] bits_used
);
   localparam int CW = $clog2(WIDTH + 1);
   localparam int IW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic [WIDTH-1:0] a_sh, b_sh;
   logic             e_r, l_r, g_r;
   logic             e_s, l_s, g_s;
   logic [IW-1:0]    idx;
   logic [CW-1:0]    cnt;
   logic             finish;

   bit_comparator u_slice (
      .a     (a_sh[WIDTH-1]),
      .b     (b_sh[WIDTH-1]),
      .e     (e_r),
      .l     (l_r),
      .g     (g_r),
      .e_nxt (e_s),
      .l_nxt (l_s),
      .g_nxt (g_s)
   );

   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Stop as soon as the cascade has resolved, or after the LSB.
   always_comb begin
      state_nxt = state;
      finish    = 1'b0;
      case (state)
         IDLE: if (start) state_nxt = RUN;
         RUN: begin
            finish = ~e_s || (idx == '0);
            if (finish) state_nxt = DONE;
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   assign busy = (state == RUN);
   assign done = (state == DONE);

   always_ff @(posedge clk) begin
      if (rst) begin
         a_sh      <= '0;
         b_sh      <= '0;
         e_r       <= 1'b0;
         l_r       <= 1'b0;
         g_r       <= 1'b0;
         idx       <= '0;
         cnt       <= '0;
         eq        <= 1'b0;
         lt        <= 1'b0;
         gt        <= 1'b0;
         bits_used <= '0;
      end else begin
         case (state)
            IDLE: if (start) begin
               a_sh      <= a_in;
               b_sh      <= b_in;
               e_r       <= 1'b1;
               l_r       <= 1'b0;
               g_r       <= 1'b0;
               idx       <= IW'(WIDTH - 1);
               cnt       <= '0;
               eq        <= 1'b0;
               lt        <= 1'b0;
               gt        <= 1'b0;
               bits_used <= '0;
            end
            RUN: begin
               e_r  <= e_s;
               l_r  <= l_s;
               g_r  <= g_s;
               a_sh <= a_sh << 1;
               b_sh <= b_sh << 1;
               cnt  <= cnt + CW'(1);
               if (finish) begin
                  eq        <= e_s;
                  lt        <= l_s;
                  gt        <= g_s;
                  bits_used <= cnt + CW'(1);
               end else begin
                  idx <= idx - IW'(1);
               end
            end
            default: ;
         endcase
      end
   end
endmodule

// File: doc/serial_word_comparator.md
# serial_word_comparator

Sequential magnitude comparator for two WIDTH-bit unsigned words, built around the team's one-bit cascadable `bit_comparator` slice. A single slice instance is time-shared across all bit positions, MSB first: the block shifts operand bits into it and feeds the slice's E/L/G outputs back into its e/l/g inputs each cycle. It stops early on the first differing bit and reports eq/lt/gt with a start/done handshake. It sits between register-file operands and the control unit wherever a compact, multi-cycle compare is acceptable.

## Interface
- WIDTH, 8, operand width in bits; legal range 1..32.
- clk  input  1  rising-edge clock.
- rst  input  1  synchronous, active-high reset.
- start  input  1  request a compare; sampled only in IDLE.
- a_in  input  WIDTH  operand A, unsigned; captured when start is accepted.
- b_in  input  WIDTH  operand B, unsigned; captured when start is accepted.
- busy  output  1  high while in RUN.
- done  output  1  single-cycle pulse; results are valid in this cycle.
- eq  output  1  A == B.
- lt  output  1  A < B.
- gt  output  1  A > B.
- bits_used  output  $clog2(WIDTH+1)  number of bit positions examined.

## Operation
- Slice function (bit_comparator, combinational):
  - E = e & (a ~^ b)
  - L = l | (e & ~a & b)
  - G = g | (e & a & ~b)
- One slice instance is driven from internal registers: a_sh/b_sh shift registers (MSB presented) and e_r/l_r/g_r cascade state.
- FSM states: IDLE, RUN, DONE.
- IDLE, on start=1:
  - load a_sh=a_in, b_sh=b_in.
  - set e_r=1, l_r=0, g_r=0, idx=WIDTH-1, cnt=0.
  - clear eq/lt/gt/bits_used to 0.
  - go to RUN.
- RUN, each edge:
  - e_r/l_r/g_r <= slice E/L/G.
  - shift a_sh/b_sh left by one; cnt <= cnt+1.
  - if slice E==0 or idx==0: go to DONE and register eq=E, lt=L, gt=G, bits_used=cnt+1.
  - otherwise idx <= idx-1 and stay in RUN.
- DONE: done=1 for exactly this cycle; unconditionally go to IDLE. A start seen in DONE is ignored.
- eq/lt/gt/bits_used hold their values from DONE until the next accepted start clears them.
- Exactly one of eq/lt/gt is 1 after any completed compare. All three are 0 in reset and while a compare is in progress.
- start while busy (RUN) is ignored. Operand inputs may change freely after capture.

## Timing
- Reset values: busy=0, done=0, eq=0, lt=0, gt=0, bits_used=0; FSM=IDLE; shift/cascade registers cleared. Reset has priority over all other inputs.
- start is accepted at edge T0. busy=1 from T0 until the edge that enters DONE.
- Compare latency is k = bits_used edges, where k = (index of first differing bit, counted from the MSB) + 1, or WIDTH if the operands are equal.
- done is high in the cycle following edge T0+k. The earliest next accepted start is at edge T0+k+2, since IDLE must be re-entered first.
- rst asserted mid-RUN or in DONE: next cycle is IDLE with all outputs at reset values; the in-flight result is discarded and no done pulse occurs.
- WIDTH=1: every compare takes exactly 1 RUN edge.

## Test plan
- Reset: hold rst 2 cycles with start=1 and random operands -> all outputs 0, busy never rises.
- Equal operands, a_in=0xA5, b_in=0xA5, WIDTH=8 -> busy for 8 cycles, then done pulse with eq=1, lt=0, gt=0, bits_used=8; outputs hold afterwards.
- MSB mismatch, a_in=0x80, b_in=0x7F -> done 1 cycle after acceptance, gt=1, bits_used=1.
- LSB mismatch, a_in=0x12, b_in=0x13 -> lt=1, bits_used=8. Swapped operands -> gt=1, bits_used=8.
- Handshake: hold start=1 continuously with operands changing each cycle -> only the operands present at each IDLE acceptance are compared; start in the DONE cycle is ignored; results are cleared on each new acceptance.
- Reset mid-operation: start a=0x00, b=0x00, assert rst 3 cycles later -> IDLE, outputs 0, no done pulse; a following compare a=0x01, b=0x02 -> lt=1, bits_used=7.
